// File: rtl/pattern_detector_param.sv
// Parametrised serial bit-pattern detector with a runtime-loadable pattern, overlap or
// non-overlap restart, a Mealy match, a registered match and a saturating match counter.
module pattern_detector_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b0111,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_value,
  output logic             match,
  output logic             match_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int          FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_reg;
  logic [PAT_W-2:0]  hist;
  logic [PAT_W-2:0]  hist_nxt;
  logic [FILL_W-1:0] fill;
  logic              full;
  logic              cnt_sat;
  logic              restart;

  // Newest bit enters at the LSB; the oldest held bit falls off the top.
  generate
    if (PAT_W == 2) begin : g_shift1
      assign hist_nxt = in_bit;
    end else begin : g_shiftn
      assign hist_nxt = {hist[PAT_W-3:0], in_bit};
    end
  endgenerate

  assign full    = (fill == FULL);
  assign cnt_sat = &match_cnt;

  // The fill guard keeps an all-zero pattern from matching zero-initialised history.
  assign match = nRST & in_valid & ~pat_load & ~clr & full & ({hist, in_bit} == pat_reg);

  // Non-overlap mode discards the matched bits so none of them start the next match.
  assign restart = match & ~OVERLAP;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pat_reg   <= PATTERN;
      hist      <= '0;
      fill      <= '0;
      match_q   <= 1'b0;
      match_cnt <= '0;
    end else if (clr) begin
      hist      <= '0;
      fill      <= '0;
      match_q   <= 1'b0;
      match_cnt <= '0;
    end else begin
      match_q <= match;
      if (pat_load) begin
        pat_reg <= pat_value;
        hist    <= '0;
        fill    <= '0;
      end else if (in_valid) begin
        if (restart) begin
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= hist_nxt;
          fill <= full ? fill : fill + 1'b1;
        end
        if (match && !cnt_sat)
          match_cnt <= match_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_detector_param.sv
// Drives three detector configurations from one stream; a bit-string reference model
// feeds per-instance expectation queues that a negedge monitor drains and compares.
module tb_pattern_detector_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_value = 4'b0;
  logic [1:0] pat_value2;

  logic       m0, mq0, m1, mq1, m2, mq2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  assign pat_value2 = pat_value[1:0];

  always #5 clk = ~clk;

  pattern_detector_param #(.PAT_W(4), .PATTERN(4'b0111), .OVERLAP(1'b1), .CNT_W(8)) dut0 (
    .CLK(clk), .nRST(rst_n), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
    .pat_load(pat_load), .pat_value(pat_value), .match(m0), .match_q(mq0), .match_cnt(cnt0));

  pattern_detector_param #(.PAT_W(4), .PATTERN(4'b0111), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
    .CLK(clk), .nRST(rst_n), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
    .pat_load(pat_load), .pat_value(pat_value), .match(m1), .match_q(mq1), .match_cnt(cnt1));

  pattern_detector_param #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) dut2 (
    .CLK(clk), .nRST(rst_n), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
    .pat_load(pat_load), .pat_value(pat_value2), .match(m2), .match_q(mq2), .match_cnt(cnt2));

  typedef struct {
    bit m;
    bit mq;
    int cnt;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int failures = 0;

  // Reference model: bits received since the last restart form a string; a match is
  // the last PAT_W of them equalling the pattern, once at least PAT_W have arrived.
  int pw[3]       = '{4, 4, 2};
  bit ov[3]       = '{1'b1, 1'b0, 1'b1};
  int cmax[3]     = '{255, 255, 3};
  int rst_pat[3]  = '{7, 7, 3};
  int hv[3], hc[3], pat[3], cnt[3];
  bit mqm[3];

  task automatic model_step(input int d, input bit rn, input bit vld, input bit b,
                            input bit pl, input int pv, input bit cl, output exp_t e);
    int mask;
    bit m;
    mask = (1 << pw[d]) - 1;
    if (!rn) begin
      pat[d] = rst_pat[d]; hv[d] = 0; hc[d] = 0; cnt[d] = 0; mqm[d] = 1'b0;
      e.m = 1'b0; e.mq = 1'b0; e.cnt = 0;
      return;
    end
    m = vld && !pl && !cl && (hc[d] >= pw[d] - 1) && ((((hv[d] << 1) | b) & mask) == pat[d]);
    e.m = m; e.mq = mqm[d]; e.cnt = cnt[d];
    if (cl) begin
      hv[d] = 0; hc[d] = 0; cnt[d] = 0; mqm[d] = 1'b0;
    end else if (pl) begin
      pat[d] = pv & mask; hv[d] = 0; hc[d] = 0; mqm[d] = 1'b0;
    end else begin
      mqm[d] = m;
      if (vld) begin
        if (m && !ov[d]) begin
          hv[d] = 0; hc[d] = 0;
        end else begin
          hv[d] = ((hv[d] << 1) | b) & 16'hffff;
          hc[d] = (hc[d] < 16) ? hc[d] + 1 : 16;
        end
        if (m && cnt[d] < cmax[d]) cnt[d]++;
      end
    end
  endtask

  // One stimulus cycle: drive just after the rising edge, queue the expected outputs.
  task automatic cyc(input bit rn, input bit vld, input bit b, input bit pl,
                     input logic [3:0] pv, input bit cl);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; in_valid = vld; in_bit = b; pat_load = pl; pat_value = pv; clr = cl;
    model_step(0, rn, vld, b, pl, int'(pv), cl, e); q0.push_back(e);
    model_step(1, rn, vld, b, pl, int'(pv), cl, e); q1.push_back(e);
    model_step(2, rn, vld, b, pl, int'(pv), cl, e); q2.push_back(e);
  endtask

  task automatic bit_in(input bit b);
    cyc(1'b1, 1'b1, b, 1'b0, 4'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'b0, 1'b0);
  endtask

  task automatic spot(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic cmp(input string nm, input exp_t e, input bit m, input bit mq, input int c);
    checks++;
    if (m !== e.m || mq !== e.mq || c != e.cnt) begin
      failures++;
      $display("FAIL %s @%0t: got match=%0b match_q=%0b cnt=%0d expected match=%0b match_q=%0b cnt=%0d",
               nm, $time, m, mq, c, e.m, e.mq, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin e = q0.pop_front(); cmp("dut0", e, m0, mq0, int'(cnt0)); end
    if (q1.size() > 0) begin e = q1.pop_front(); cmp("dut1", e, m1, mq1, int'(cnt1)); end
    if (q2.size() > 0) begin e = q2.pop_front(); cmp("dut2", e, m2, mq2, int'(cnt2)); end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pv;
    int r;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0);
    // Defaults: 0,1,1,1,1
    bit_in(0); bit_in(1); bit_in(1); bit_in(1); bit_in(1);
    idle();
    #2;
    spot("t1_cnt0", int'(cnt0), 1);
    spot("t2_cnt2_saturated", int'(cnt2), 3);
    // Load 1010 and stream 1,0,1,0,1,0,1,0
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b0);
    for (int i = 0; i < 8; i++) bit_in(1'(~i[0]));
    idle();
    #2;
    spot("t2_cnt0_overlap", int'(cnt0), 4);
    spot("t2_cnt1_nonoverlap", int'(cnt1), 3);
    // Clear, restore 0111, then 0,1,1,1 with gaps of toggling in_bit
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0111, 1'b0);
    bit_in(0); repeat (3) idle();
    bit_in(1); repeat (3) idle();
    bit_in(1); repeat (3) idle();
    bit_in(1); idle();
    #2;
    spot("t3_cnt0_gaps", int'(cnt0), 1);
    // pat_load with a completing bit discards it; clr beats pat_load
    bit_in(0); bit_in(1); bit_in(1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b0111, 1'b0);
    bit_in(0); bit_in(1); bit_in(1); bit_in(1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b1);
    idle();
    #2;
    spot("t5_cnt0_after_clr", int'(cnt0), 0);
    bit_in(0); bit_in(1); bit_in(1); bit_in(1); idle();
    #2;
    spot("t5_pattern_kept", int'(cnt0), 1);
    // Reset mid-sequence after a pattern change
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0);
    bit_in(0); bit_in(1); bit_in(1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0);
    bit_in(1);
    bit_in(0); bit_in(1); bit_in(1); bit_in(1); idle();
    #2;
    spot("t6_cnt0_after_reset", int'(cnt0), 1);
    // Randomised traffic, including all-zero / all-one patterns and rare resets
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 199);
      case ($urandom_range(0, 4))
        0: pv = 4'b0111;
        1: pv = 4'b1010;
        2: pv = 4'b0000;
        3: pv = 4'b1111;
        default: pv = 4'($urandom_range(0, 15));
      endcase
      cyc(r != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          (r >= 3 && r < 8), pv, (r >= 1 && r < 3));
    end
    idle();
    repeat (2) @(negedge clk);
    #1;
    spot("queues_drained", q0.size() + q1.size() + q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
